mult_seq_param: RTL

- Parametrised multi-cycle multiplier: FSM and datapath in one block.
- Computes A_WIDTH x B_WIDTH products by accumulating one A_CHUNK x B_CHUNK partial product per cycle.
- Adds a signed/unsigned mode, a start/busy/done handshake, and a held result register.
- Successor to the fixed 32x32 byte-by-halfword multiplier; drops into the same arithmetic subsystem.

---
 rtl/mult_seq_param.sv | 96 +++++++++
 1 files changed

// File: rtl/mult_seq_param.sv
// mult_seq_param: multi-cycle chunked multiplier with signed mode and start/busy/done handshake
module mult_seq_param #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       is_signed,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);
  localparam int NA = A_CHUNK > 0 ? A_WIDTH / A_CHUNK : 1;
  localparam int NB = B_CHUNK > 0 ? B_WIDTH / B_CHUNK : 1;
  localparam int P  = A_WIDTH + B_WIDTH;
  localparam int IW = NA > 1 ? $clog2(NA) : 1;
  localparam int JW = NB > 1 ? $clog2(NB) : 1;

  if (A_CHUNK <= 0 || B_CHUNK <= 0 ||
      A_WIDTH % (A_CHUNK > 0 ? A_CHUNK : 1) != 0 ||
      B_WIDTH % (B_CHUNK > 0 ? B_CHUNK : 1) != 0) begin : g_bad_params
    $error("mult_seq_param: operand widths must be non-zero multiples of their chunk sizes");
  end

  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

  state_t             state;
  logic [A_WIDTH-1:0] amag;
  logic [B_WIDTH-1:0] bmag;
  logic               neg;
  logic [P-1:0]       acc;
  logic [IW-1:0]      i;
  logic [JW-1:0]      j;
  logic [A_CHUNK-1:0] a_sl;
  logic [B_CHUNK-1:0] b_sl;
  logic [P-1:0]       pp;
  logic               last_i;
  logic               last_j;

  // current partial product, already shifted to its weight
  always_comb begin
    a_sl   = amag[i*A_CHUNK +: A_CHUNK];
    b_sl   = bmag[j*B_CHUNK +: B_CHUNK];
    pp     = (P'(a_sl) * P'(b_sl)) << (i*A_CHUNK + j*B_CHUNK);
    last_i = i == IW'(NA-1);
    last_j = j == JW'(NB-1);
  end

  // sequencer: latch magnitudes, accumulate one chunk pair per cycle, then apply sign
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      amag    <= '0;
      bmag    <= '0;
      neg     <= 1'b0;
      i       <= '0;
      j       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          amag  <= (is_signed && a[A_WIDTH-1]) ? -a : a;
          bmag  <= (is_signed && b[B_WIDTH-1]) ? -b : b;
          neg   <= is_signed & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
          acc   <= '0;
          i     <= '0;
          j     <= '0;
          busy  <= 1'b1;
          state <= MUL;
        end
        MUL: begin
          acc <= acc + pp;
          i   <= last_i ? '0 : i + 1'b1;
          if (last_i) j <= last_j ? '0 : j + 1'b1;
          if (last_i && last_j) state <= FIX;
        end
        FIX: begin
          product <= neg ? ~acc + 1'b1 : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
